// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: latches one byte and shifts start, d0..d7, parity and stop onto
// the line LSB first, advancing one bit per baud_tick.
module uart_tx_frame_serializer #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       data_tx,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] data_reg, data_next;
  logic       parity_reg, parity_next;
  logic       tx_reg, tx_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      data_reg    <= 8'd0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      data_reg    <= data_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    parity_next  = parity_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        // A tick coinciding with the accept is deliberately ignored; ARM waits for the next one.
        if (data_valid) begin
          data_next   = data_in;
          parity_next = PARITY_ODD ? ~^data_in : ^data_in;
          busy_next   = 1'b1;
          state_next  = ARM;
        end
      end
      ARM: begin
        if (baud_tick) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_next      = data_reg[0];
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg == 3'd7) begin
            tx_next    = parity_reg;
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            tx_next      = data_reg[bit_cnt_reg + 3'd1];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign data_tx   = tx_reg;
  assign done_flag = done_reg;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: an even- and an odd-parity instance share stimulus; a
// negedge monitor reassembles each frame off the line and checks it against a queued reference.
module tb_uart_tx_frame_serializer;

  logic       clock;
  logic       reset;
  logic       baud_tick;
  logic       data_valid;
  logic [7:0] data_in;
  logic       busy0, tx0, done0;
  logic       busy1, tx1, done1;

  uart_tx_frame_serializer #(.PARITY_ODD(1'b0)) dut_even (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .data_valid(data_valid),
    .data_in(data_in), .busy(busy0), .data_tx(tx0), .done_flag(done0)
  );

  uart_tx_frame_serializer #(.PARITY_ODD(1'b1)) dut_odd (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .data_valid(data_valid),
    .data_in(data_in), .busy(busy1), .data_tx(tx1), .done_flag(done1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int tick_period = 16;
  int frames_sent = 0;

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];

  bit          in_frame[2];
  int          idx[2];
  logic [10:0] got[2];
  int          glitch[2];
  logic        prev_tx[2];
  int          done_cnt[2];
  int          frames_done[2];
  int          start_cyc[2];
  int          prev_start_cyc[2];
  bit          tick_pend = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Baud generator: one-cycle pulse every tick_period clocks, changed only between frames.
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tcnt++;
      if (tcnt >= tick_period) begin
        tcnt = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int actual, input int required);
    total_cnt++;
    if (actual == required) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, required);
  endtask

  // Wire order bit i of the returned word is the i-th bit on the line.
  function automatic logic [10:0] ref_frame(input logic [7:0] b, input bit odd);
    int  ones;
    bit  par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 1) != odd;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic mon_step(input int k);
    logic        tx, bz, dn;
    logic [10:0] e;
    tx = (k == 0) ? tx0 : tx1;
    bz = (k == 0) ? busy0 : busy1;
    dn = (k == 0) ? done0 : done1;
    if (dn) done_cnt[k]++;
    if (!in_frame[k]) begin
      if (tx == 1'b0) begin
        in_frame[k]       = 1'b1;
        got[k]            = 11'd0;
        idx[k]            = 1;
        glitch[k]         = bz ? 0 : 1;
        prev_start_cyc[k] = start_cyc[k];
        start_cyc[k]      = cyc;
      end
    end else if (tick_pend) begin
      if (idx[k] < 11) begin
        got[k][idx[k]] = tx;
        idx[k]++;
        if (!bz) glitch[k]++;
      end else begin
        chk($sformatf("done_flag_dut%0d", k), int'(dn), 1);
        chk($sformatf("busy_after_stop_dut%0d", k), int'(bz), 0);
        chk($sformatf("line_stable_dut%0d", k), glitch[k], 0);
        if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
        else begin
          e = 11'h7ff;
          chk($sformatf("unexpected_frame_dut%0d", k), 1, 0);
        end
        chk($sformatf("frame_dut%0d", k), int'(got[k]), int'(e));
        $display("frame dut%0d: line 0x%03h reference 0x%03h", k, got[k], e);
        frames_done[k]++;
        in_frame[k] = 1'b0;
      end
    end else begin
      if (tx != prev_tx[k]) glitch[k]++;
      if (dn || !bz) glitch[k]++;
    end
    prev_tx[k] = tx;
  endtask

  initial forever begin
    @(negedge clock);
    if (reset) begin
      in_frame[0] = 1'b0;
      in_frame[1] = 1'b0;
    end else begin
      mon_step(0);
      mon_step(1);
    end
    tick_pend = baud_tick;
  end

  task automatic send(input logic [7:0] b, input bit align, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while ((busy0 || busy1 || (align && !baud_tick)) && n < 5000);
    if (n >= 5000) begin
      chk("send_wait_timeout", 1, 0);
      return;
    end
    data_valid = 1'b1;
    data_in    = b;
    @(posedge clock);
    #2;
    acc_cyc = cyc;
    exp_q0.push_back(ref_frame(b, 1'b0));
    exp_q1.push_back(ref_frame(b, 1'b1));
    frames_sent++;
    data_valid = 1'b0;
    data_in    = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1 || in_frame[0] || in_frame[1]) && n < 5000) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_bit(input int target);
    int n;
    n = 0;
    while (!(in_frame[0] && idx[0] >= target) && n < 2000) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (n >= 2000) chk("bit_wait_timeout", 1, 0);
  endtask

  initial begin
    int acc;
    int dc0, fd0, n;
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 1'b0; idx[k] = 0; got[k] = 11'd0; glitch[k] = 0; prev_tx[k] = 1'b1;
      done_cnt[k] = 0; frames_done[k] = 0; start_cyc[k] = 0; prev_start_cyc[k] = 0;
    end
    reset = 1'b0;
    data_valid = 1'b0;
    data_in = 8'h00;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    chk("reset_tx_dut0", int'(tx0), 1);
    chk("reset_busy_dut0", int'(busy0), 0);
    chk("reset_done_dut0", int'(done0), 0);
    chk("reset_tx_dut1", int'(tx1), 1);
    chk("reset_busy_dut1", int'(busy1), 0);
    chk("reset_done_dut1", int'(done1), 0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Idle line with ticks running and no request
    repeat (40) @(posedge clock);
    #2;
    chk("idle_tx", int'(tx0), 1);
    chk("idle_busy", int'(busy0), 0);

    tick_period = 16;
    send(8'hA5, 1'b0, acc);
    wait_idle();
    send(8'h00, 1'b0, acc);
    send(8'hFF, 1'b0, acc);
    send(8'h01, 1'b0, acc);
    wait_idle();

    // Request while busy must be dropped
    send(8'hA5, 1'b0, acc);
    wait_bit(4);
    data_valid = 1'b1;
    data_in    = 8'h3C;
    @(posedge clock);
    #2 data_valid = 1'b0;
    wait_idle();
    repeat (3 * tick_period) @(posedge clock);
    #2;
    chk("no_queued_frame", frames_done[0], frames_sent);
    chk("still_idle_busy", int'(busy0), 0);

    // Request coinciding with a tick: start bit waits for the following tick
    send(8'h5A, 1'b1, acc);
    wait_bit(1);
    chk("tick_in_accept_latency", start_cyc[0] - acc, tick_period);
    wait_idle();

    // Back-to-back: second start bit lands on the first tick after done_flag
    send(8'h55, 1'b0, acc);
    send(8'hAA, 1'b0, acc);
    wait_bit(1);
    chk("back_to_back_spacing", start_cyc[0] - prev_start_cyc[0], 12 * tick_period);
    wait_idle();

    // Randomised bursts at assorted tick periods
    for (int r = 0; r < 4; r++) begin
      wait_idle();
      tick_period = $urandom_range(2, 12);
      for (int j = 0; j < 3; j++) begin
        send(8'($urandom), 1'b0, acc);
        repeat ($urandom_range(0, 20)) @(posedge clock);
      end
    end
    wait_idle();

    // Reset in the middle of data bit 3 aborts the frame
    tick_period = 16;
    send(8'($urandom), 1'b0, acc);
    wait_bit(5);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx_dut0", int'(tx0), 1);
    chk("abort_busy_dut0", int'(busy0), 0);
    chk("abort_tx_dut1", int'(tx1), 1);
    void'(exp_q0.pop_back());
    void'(exp_q1.pop_back());
    frames_sent--;
    dc0 = done_cnt[0];
    fd0 = frames_done[0];
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    n = 0;
    repeat (13 * tick_period) @(posedge clock);
    #2;
    chk("abort_no_done", done_cnt[0] - dc0, n);
    chk("abort_no_frame", frames_done[0] - fd0, n);
    chk("abort_line_idle", int'(tx0), 1);
    send(8'h81, 1'b0, acc);
    wait_idle();

    repeat (4) @(posedge clock);
    #2;
    chk("frames_dut0", frames_done[0], frames_sent);
    chk("frames_dut1", frames_done[1], frames_sent);
    chk("done_count_dut0", done_cnt[0], frames_sent);
    chk("done_count_dut1", done_cnt[1], frames_sent);
    chk("queue_left_dut0", exp_q0.size(), 0);
    chk("queue_left_dut1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
